// File: rtl/rvm_mem_ctrl_pkg.sv
// Shared encodings for the memory controller: access sizes, FSM states and
// the misalignment rule used when a request is granted.
package rvm_mem_ctrl_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_R   = 2'b11;
    localparam logic [3:0] BEN_READ = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    // Reserved size is always rejected; otherwise the low address bits must
    // be aligned to the access width.
    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = lo[0];
            SIZE_W:  mis = (lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/rvm_mem_ctrl_if.sv
// Bundle of the fetch port, data port and memory pins of rvm_mem_ctrl.
interface rvm_mem_ctrl_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rsp_valid;
    logic [31:0] i_rdata;
    logic        i_error;

    logic        d_req;
    logic        d_wen;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic        d_error;
    logic        d_misaligned;

    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic [3:0]  mem_b_en;
    logic        mem_error;
    logic        mem_stall;

    modport slave (
        input  i_req, i_addr, d_req, d_wen, d_size, d_signed, d_addr, d_wdata,
               mem_rdata, mem_error, mem_stall,
        output i_rsp_valid, i_rdata, i_error,
               d_rsp_valid, d_rdata, d_error, d_misaligned,
               mem_addr, mem_wdata, mem_c_en, mem_b_en
    );

    modport master (
        output i_req, i_addr, d_req, d_wen, d_size, d_signed, d_addr, d_wdata,
               mem_rdata, mem_error, mem_stall,
        input  i_rsp_valid, i_rdata, i_error,
               d_rsp_valid, d_rdata, d_error, d_misaligned,
               mem_addr, mem_wdata, mem_c_en, mem_b_en
    );

endinterface

// File: rtl/rvm_lane_steer.sv
// Combinational byte-lane steering: write enables and replicated store data,
// plus lane selection and sign/zero extension of load data.
module rvm_lane_steer
    import rvm_mem_ctrl_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    input  logic        i_signed,
    output logic [3:0]  o_b_en,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select and per-size steering
    always_comb begin
        w_byte  = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_b_en  = BEN_READ;
        o_wdata = 32'd0;
        o_rdata = 32'd0;
        case (i_size)
            SIZE_B: begin
                o_b_en  = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            SIZE_H: begin
                o_b_en  = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_signed & w_half[15]}}, w_half};
            end
            SIZE_W: begin
                o_b_en  = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
            default: begin
                o_b_en  = BEN_READ;
                o_wdata = 32'd0;
                o_rdata = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/rvm_mem_ctrl.sv
// Shares the single memory port between instruction fetch and data access:
// arbitration, stall holding with time-out, lane steering and response pulses.
module rvm_mem_ctrl
    import rvm_mem_ctrl_pkg::*;
#(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic          clk,
    input  logic          resetn,
    rvm_mem_ctrl_if.slave bus
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_ptr_data;
    logic        w_ptr_nxt;
    logic [31:0] r_stall_cnt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] w_cnt_inc;

    logic        r_is_data;
    logic        r_wen;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_addr_lo;

    logic        w_gnt_data;
    logic        w_grant;
    logic [1:0]  w_sel_size;
    logic [31:0] w_sel_addr;
    logic        w_sel_wen;
    logic        w_sel_signed;
    logic        w_sel_mis;

    logic [1:0]  w_st_size;
    logic [1:0]  w_st_lo;
    logic [3:0]  w_st_ben;
    logic [31:0] w_st_wdata;
    logic [31:0] w_st_rdata;

    logic        w_to_rsp;
    logic        w_rsp_is_data;
    logic        w_rsp_err;
    logic        w_rsp_mis;
    logic [31:0] w_rsp_data;
    logic        w_rsp_i;
    logic        w_rsp_d;

    logic        r_mem_c_en;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_b_en;
    logic [31:0] r_mem_wdata;
    logic        r_i_rsp_valid;
    logic [31:0] r_i_rdata;
    logic        r_i_error;
    logic        r_d_rsp_valid;
    logic [31:0] r_d_rdata;
    logic        r_d_error;
    logic        r_d_misaligned;

    // On a tie the pointer decides; without round-robin data always wins.
    assign w_gnt_data   = bus.d_req & (~bus.i_req | (ROUND_ROBIN == 1'b0) | r_ptr_data);
    assign w_sel_size   = w_gnt_data ? bus.d_size : SIZE_W;
    assign w_sel_addr   = w_gnt_data ? bus.d_addr : bus.i_addr;
    assign w_sel_wen    = w_gnt_data & bus.d_wen;
    assign w_sel_signed = w_gnt_data & bus.d_signed;
    assign w_sel_mis    = addr_misaligned(w_sel_size, w_sel_addr[1:0]);
    assign w_cnt_inc    = r_stall_cnt + 32'd1;

    // The steering block serves the incoming request in IDLE and the latched one afterwards
    assign w_st_size = (r_state == ST_IDLE) ? w_sel_size : r_size;
    assign w_st_lo   = (r_state == ST_IDLE) ? w_sel_addr[1:0] : r_addr_lo;

    rvm_lane_steer u_steer (
        .i_size    (w_st_size),
        .i_addr_lo (w_st_lo),
        .i_wdata   (bus.d_wdata),
        .i_rdata   (bus.mem_rdata),
        .i_signed  (r_signed),
        .o_b_en    (w_st_ben),
        .o_wdata   (w_st_wdata),
        .o_rdata   (w_st_rdata)
    );

    // Next-state, arbitration and response content
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr_data;
        w_cnt_nxt     = r_stall_cnt;
        w_grant       = 1'b0;
        w_to_rsp      = 1'b0;
        w_rsp_is_data = r_is_data;
        w_rsp_err     = 1'b0;
        w_rsp_mis     = 1'b0;
        w_rsp_data    = 32'd0;
        case (r_state)
            ST_IDLE: begin
                w_rsp_is_data = w_gnt_data;
                if (bus.i_req || bus.d_req) begin
                    w_grant   = 1'b1;
                    w_cnt_nxt = 32'd0;
                    if (bus.i_req && bus.d_req) begin
                        w_ptr_nxt = ~w_gnt_data;
                    end else begin
                        w_ptr_nxt = r_ptr_data;
                    end
                    if (w_sel_mis) begin
                        w_state_nxt = ST_RSP;
                        w_to_rsp    = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_rsp_mis   = 1'b1;
                    end else begin
                        w_state_nxt = ST_MEM;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (!bus.mem_stall) begin
                    w_state_nxt = ST_RSP;
                    w_to_rsp    = 1'b1;
                    w_rsp_err   = bus.mem_error;
                    w_rsp_data  = (bus.mem_error || r_wen) ? 32'd0 : w_st_rdata;
                end else if ((STALL_LIMIT != 32'd0) && (w_cnt_inc == 32'(STALL_LIMIT))) begin
                    w_state_nxt = ST_RSP;
                    w_to_rsp    = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_cnt_nxt   = w_cnt_inc;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_RSP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_rsp_i = w_to_rsp & ~w_rsp_is_data;
    assign w_rsp_d = w_to_rsp & w_rsp_is_data;

    // State, arbitration pointer and stall counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_ptr_data  <= 1'b1;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr_data  <= w_ptr_nxt;
            r_stall_cnt <= w_cnt_nxt;
        end
    end

    // Request fields captured at grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_data <= 1'b0;
            r_wen     <= 1'b0;
            r_signed  <= 1'b0;
            r_size    <= SIZE_B;
            r_addr_lo <= 2'b00;
        end else if (w_grant) begin
            r_is_data <= w_gnt_data;
            r_wen     <= w_sel_wen;
            r_signed  <= w_sel_signed;
            r_size    <= w_sel_size;
            r_addr_lo <= w_sel_addr[1:0];
        end
    end

    // Memory pins: loaded at grant, held through stalls, cleared outside MEM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_c_en  <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_b_en  <= BEN_READ;
            r_mem_wdata <= 32'd0;
        end else begin
            r_mem_c_en <= (w_state_nxt == ST_MEM);
            if (w_grant && !w_sel_mis) begin
                r_mem_addr  <= {w_sel_addr[31:2], 2'b00};
                r_mem_b_en  <= w_sel_wen ? w_st_ben : BEN_READ;
                r_mem_wdata <= w_sel_wen ? w_st_wdata : 32'd0;
            end else if (w_state_nxt != ST_MEM) begin
                r_mem_addr  <= 32'd0;
                r_mem_b_en  <= BEN_READ;
                r_mem_wdata <= 32'd0;
            end
        end
    end

    // Response pins: one-cycle pulse with data, zero otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_i_rsp_valid  <= 1'b0;
            r_i_rdata      <= 32'd0;
            r_i_error      <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            r_d_rdata      <= 32'd0;
            r_d_error      <= 1'b0;
            r_d_misaligned <= 1'b0;
        end else begin
            r_i_rsp_valid  <= w_rsp_i;
            r_i_rdata      <= w_rsp_i ? w_rsp_data : 32'd0;
            r_i_error      <= w_rsp_i & w_rsp_err;
            r_d_rsp_valid  <= w_rsp_d;
            r_d_rdata      <= w_rsp_d ? w_rsp_data : 32'd0;
            r_d_error      <= w_rsp_d & w_rsp_err;
            r_d_misaligned <= w_rsp_d & w_rsp_mis;
        end
    end

    assign bus.mem_c_en     = r_mem_c_en;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_b_en     = r_mem_b_en;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.i_rsp_valid  = r_i_rsp_valid;
    assign bus.i_rdata      = r_i_rdata;
    assign bus.i_error      = r_i_error;
    assign bus.d_rsp_valid  = r_d_rsp_valid;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.d_error      = r_d_error;
    assign bus.d_misaligned = r_d_misaligned;

endmodule

// File: tb/tb_rvm_mem_ctrl.sv
// Self-checking bench: directed and randomized transactions against an
// arithmetic reference model, plus arbitration, time-out and reset scenarios.
module tb_rvm_mem_ctrl;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    rvm_mem_ctrl_if bus_a ();
    rvm_mem_ctrl_if bus_b ();

    rvm_mem_ctrl #(.ROUND_ROBIN(1'b1), .STALL_LIMIT(255)) u_dut (
        .clk(clk), .resetn(resetn), .bus(bus_a));
    rvm_mem_ctrl #(.ROUND_ROBIN(1'b0), .STALL_LIMIT(4)) u_dut_fp (
        .clk(clk), .resetn(resetn), .bus(bus_b));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit exp_misaligned(input logic [1:0] size, input logic [31:0] addr);
        int unsigned nb;
        if (size == 2'd3) return 1'b1;
        nb = 32'd1 << size;
        return (addr % nb) != 32'd0;
    endfunction

    function automatic logic [3:0] exp_ben(input logic [1:0] size, input logic [31:0] addr);
        int unsigned lo;
        lo = addr % 32'd4;
        case (size)
            2'd0:    return 4'(32'd1 << lo);
            2'd1:    return 4'(32'd3 << lo);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'd0:    return (wd & 32'h0000_00FF) * 32'h0101_0101;
            2'd1:    return (wd & 32'h0000_FFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [1:0] size, input bit sgn,
                                              input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rd >> (32'd8 * (addr % 32'd4));
        case (size)
            2'd0: begin
                v = sh & 32'h0000_00FF;
                if (sgn && v >= 32'h80) v = v - 32'h100;
            end
            2'd1: begin
                v = sh & 32'h0000_FFFF;
                if (sgn && v >= 32'h8000) v = v - 32'h1_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [137:0] outs_a();
        return {bus_a.i_rsp_valid, bus_a.i_rdata, bus_a.i_error, bus_a.d_rsp_valid,
                bus_a.d_rdata, bus_a.d_error, bus_a.d_misaligned, bus_a.mem_addr,
                bus_a.mem_wdata, bus_a.mem_c_en, bus_a.mem_b_en};
    endfunction

    function automatic logic [137:0] outs_b();
        return {bus_b.i_rsp_valid, bus_b.i_rdata, bus_b.i_error, bus_b.d_rsp_valid,
                bus_b.d_rdata, bus_b.d_error, bus_b.d_misaligned, bus_b.mem_addr,
                bus_b.mem_wdata, bus_b.mem_c_en, bus_b.mem_b_en};
    endfunction

    task automatic idle_inputs();
        bus_a.i_req = 1'b0; bus_a.i_addr = 32'd0; bus_a.d_req = 1'b0; bus_a.d_wen = 1'b0;
        bus_a.d_size = 2'd0; bus_a.d_signed = 1'b0; bus_a.d_addr = 32'd0; bus_a.d_wdata = 32'd0;
        bus_a.mem_rdata = 32'd0; bus_a.mem_error = 1'b0; bus_a.mem_stall = 1'b0;
        bus_b.i_req = 1'b0; bus_b.i_addr = 32'd0; bus_b.d_req = 1'b0; bus_b.d_wen = 1'b0;
        bus_b.d_size = 2'd0; bus_b.d_signed = 1'b0; bus_b.d_addr = 32'd0; bus_b.d_wdata = 32'd0;
        bus_b.mem_rdata = 32'd0; bus_b.mem_error = 1'b0; bus_b.mem_stall = 1'b0;
    endtask

    // One transaction on the round-robin DUT, checked cycle by cycle against the model
    task automatic run_txn(input string name, input bit is_d, input bit wen, input logic [1:0] size,
                           input bit sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int stalls, input bit merr);
        logic [1:0]  sz;
        bit          mis;
        bit          e_err;
        bit          st;
        logic [3:0]  e_ben;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic [33:0] obs;
        int          cyc;
        int          n_mem;
        int          rsp_cyc;
        sz    = is_d ? size : 2'd2;
        st    = is_d && wen;
        mis   = exp_misaligned(sz, addr);
        e_err = mis || merr;
        e_ben = st ? exp_ben(sz, addr) : 4'd0;
        e_wd  = st ? exp_wdata(sz, wdata) : 32'd0;
        e_rd  = (e_err || st) ? 32'd0 : exp_rdata(sz, sgn && is_d, addr, rdata);
        @(negedge clk);
        if (is_d) begin
            bus_a.d_req = 1'b1; bus_a.d_wen = wen; bus_a.d_size = size; bus_a.d_signed = sgn;
            bus_a.d_addr = addr; bus_a.d_wdata = wdata;
        end else begin
            bus_a.i_req = 1'b1; bus_a.i_addr = addr;
        end
        bus_a.mem_rdata = rdata; bus_a.mem_error = merr; bus_a.mem_stall = 1'b0;
        cyc = 0; n_mem = 0; rsp_cyc = 0;
        while (rsp_cyc == 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus_a.mem_c_en) begin
                n_mem++;
                checks++;
                if ({bus_a.mem_addr, bus_a.mem_b_en, bus_a.mem_wdata} !== {addr & ~32'd3, e_ben, e_wd}) begin
                    errors++;
                    $display("FAIL %s mem_bus cyc %0d: got addr=%h ben=%b wd=%h, want addr=%h ben=%b wd=%h",
                             name, cyc, bus_a.mem_addr, bus_a.mem_b_en, bus_a.mem_wdata, addr & ~32'd3, e_ben, e_wd);
                end
                bus_a.mem_stall = (n_mem <= stalls);
            end
            if (bus_a.i_rsp_valid || bus_a.d_rsp_valid) begin
                rsp_cyc = cyc;
                bus_a.i_req = 1'b0;
                bus_a.d_req = 1'b0;
                checks++;
                if ({bus_a.i_rsp_valid, bus_a.d_rsp_valid} !== (is_d ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL %s rsp_port: got i/d=%b%b, want is_d=%0d", name,
                             bus_a.i_rsp_valid, bus_a.d_rsp_valid, is_d);
                end
                obs = is_d ? {bus_a.d_rdata, bus_a.d_error, bus_a.d_misaligned}
                           : {bus_a.i_rdata, bus_a.i_error, 1'b0};
                checks++;
                if (obs !== {e_rd, e_err, is_d && mis}) begin
                    errors++;
                    $display("FAIL %s rsp_data: got rdata=%h err=%b mis=%b, want rdata=%h err=%b mis=%b",
                             name, obs[33:2], obs[1], obs[0], e_rd, e_err, is_d && mis);
                end
                checks++;
                if (rsp_cyc != (mis ? 1 : 2 + stalls) || n_mem != (mis ? 0 : 1 + stalls)) begin
                    errors++;
                    $display("FAIL %s latency: got rsp_cycle=%0d mem_cycles=%0d, want %0d and %0d",
                             name, rsp_cyc, n_mem, mis ? 1 : 2 + stalls, mis ? 0 : 1 + stalls);
                end
            end
        end
        if (rsp_cyc == 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no response in %0d cycles, want one", name, cyc);
            bus_a.i_req = 1'b0;
            bus_a.d_req = 1'b0;
        end
        bus_a.mem_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (outs_a() !== 138'd0) begin
            errors++;
            $display("FAIL %s after_rsp: got outputs=%h, want all zero", name, outs_a());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({outs_a(), outs_b()} !== 276'd0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h b=%h, want all zero", outs_a(), outs_b());
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        run_txn("fetch_0x100", 1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'h0050_0093, 0, 1'b0);
    endtask

    task automatic test_store_stall();
        run_txn("store_b_stall3", 1'b1, 1'b1, 2'd0, 1'b0, 32'h203, 32'h0000_00AB, 32'h1111_2222, 3, 1'b0);
        run_txn("store_h", 1'b1, 1'b1, 2'd1, 1'b0, 32'h206, 32'h5555_C3D4, 32'd0, 1, 1'b0);
        run_txn("store_w", 1'b1, 1'b1, 2'd2, 1'b0, 32'h208, 32'hCAFE_F00D, 32'd0, 0, 1'b0);
    endtask

    task automatic test_load_half();
        run_txn("load_h_signed", 1'b1, 1'b0, 2'd1, 1'b1, 32'h402, 32'd0, 32'h8001_1234, 0, 1'b0);
        run_txn("load_h_unsigned", 1'b1, 1'b0, 2'd1, 1'b0, 32'h402, 32'd0, 32'h8001_1234, 0, 1'b0);
        run_txn("load_b_signed", 1'b1, 1'b0, 2'd0, 1'b1, 32'h401, 32'd0, 32'h12_34_F6_78, 2, 1'b0);
    endtask

    task automatic test_misaligned();
        run_txn("mis_load_w", 1'b1, 1'b0, 2'd2, 1'b0, 32'h301, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
        run_txn("mis_store_h", 1'b1, 1'b1, 2'd1, 1'b0, 32'h401, 32'h1234, 32'd0, 0, 1'b0);
        run_txn("mis_size_r", 1'b1, 1'b0, 2'd3, 1'b0, 32'h400, 32'd0, 32'h1234_5678, 0, 1'b0);
        run_txn("mis_fetch", 1'b0, 1'b0, 2'd2, 1'b0, 32'h102, 32'd0, 32'h1234_5678, 0, 1'b0);
    endtask

    task automatic test_mem_error();
        run_txn("merr_load", 1'b1, 1'b0, 2'd2, 1'b0, 32'h700, 32'd0, 32'hDEAD_BEEF, 1, 1'b1);
        run_txn("merr_fetch", 1'b0, 1'b0, 2'd2, 1'b0, 32'h704, 32'd0, 32'hDEAD_BEEF, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  size;
        for (int n = 0; n < 40; n++) begin
            addr = $urandom();
            wd   = $urandom();
            rd   = $urandom();
            size = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'd3;
            run_txn("random", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, size,
                    $urandom_range(0, 1) == 1, addr, wd, rd, $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0);
        end
    endtask

    task automatic test_round_robin();
        bit fav_d;
        int got;
        int cyc;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        fav_d = 1'b1;
        bus_a.i_req = 1'b1; bus_a.i_addr = 32'h40;
        bus_a.d_req = 1'b1; bus_a.d_wen = 1'b0; bus_a.d_size = 2'd2; bus_a.d_addr = 32'h80;
        bus_a.mem_rdata = 32'h1357_9BDF; bus_a.mem_stall = 1'b0; bus_a.mem_error = 1'b0;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus_a.i_rsp_valid || bus_a.d_rsp_valid) begin
                checks++;
                if ({bus_a.d_rsp_valid, bus_a.i_rsp_valid} !== (fav_d ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL rr_grant %0d: got d/i=%b%b, want %s", got,
                             bus_a.d_rsp_valid, bus_a.i_rsp_valid, fav_d ? "data" : "fetch");
                end
                fav_d = ~fav_d;
                got++;
                if (got == 4) begin
                    bus_a.i_req = 1'b0;
                    bus_a.d_req = 1'b0;
                end
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d responses, want 4", got);
        end
        bus_a.i_req = 1'b0;
        bus_a.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        int got;
        int cyc;
        bus_b.i_req = 1'b1; bus_b.i_addr = 32'h40;
        bus_b.d_req = 1'b1; bus_b.d_wen = 1'b0; bus_b.d_size = 2'd2; bus_b.d_addr = 32'h80;
        bus_b.mem_rdata = 32'h2468_ACE0; bus_b.mem_stall = 1'b0; bus_b.mem_error = 1'b0;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus_b.i_rsp_valid || bus_b.d_rsp_valid) begin
                checks++;
                if ({bus_b.d_rsp_valid, bus_b.i_rsp_valid, bus_b.d_rdata} !== {2'b10, 32'h2468_ACE0}) begin
                    errors++;
                    $display("FAIL fp_grant %0d: got d/i=%b%b rdata=%h, want data grant rdata=2468ace0",
                             got, bus_b.d_rsp_valid, bus_b.i_rsp_valid, bus_b.d_rdata);
                end
                got++;
                if (got == 4) begin
                    bus_b.i_req = 1'b0;
                    bus_b.d_req = 1'b0;
                end
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL fp_count: got %0d responses, want 4", got);
        end
        bus_b.i_req = 1'b0;
        bus_b.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall_limit();
        int cyc;
        int n_mem;
        int rsp_cyc;
        @(negedge clk);
        bus_b.d_req = 1'b1; bus_b.d_wen = 1'b0; bus_b.d_size = 2'd2; bus_b.d_addr = 32'h500;
        bus_b.mem_rdata = 32'h7777_7777; bus_b.mem_stall = 1'b1; bus_b.mem_error = 1'b0;
        cyc = 0; n_mem = 0; rsp_cyc = 0;
        while (rsp_cyc == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus_b.mem_c_en) n_mem++;
            if (bus_b.d_rsp_valid || bus_b.i_rsp_valid) begin
                rsp_cyc = cyc;
                bus_b.d_req = 1'b0;
                checks++;
                if ({bus_b.d_rsp_valid, bus_b.d_error, bus_b.d_misaligned, bus_b.d_rdata} !== {3'b110, 32'd0}) begin
                    errors++;
                    $display("FAIL stall_limit_rsp: got valid=%b err=%b mis=%b rdata=%h, want 1 1 0 0",
                             bus_b.d_rsp_valid, bus_b.d_error, bus_b.d_misaligned, bus_b.d_rdata);
                end
            end
        end
        checks++;
        if (rsp_cyc != 5 || n_mem != 4) begin
            errors++;
            $display("FAIL stall_limit_timing: got rsp_cycle=%0d mem_cycles=%0d, want 5 and 4", rsp_cyc, n_mem);
        end
        bus_b.d_req = 1'b0;
        bus_b.mem_stall = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        bus_a.d_req = 1'b1; bus_a.d_wen = 1'b1; bus_a.d_size = 2'd2; bus_a.d_addr = 32'h600;
        bus_a.d_wdata = 32'hA5A5_5A5A; bus_a.mem_stall = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_a.mem_c_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got mem_c_en=%b, want 1", bus_a.mem_c_en);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (outs_a() !== 138'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got outputs=%h, want all zero", outs_a());
        end
        bus_a.d_req = 1'b0;
        bus_a.mem_stall = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_a.i_rsp_valid || bus_a.d_rsp_valid || bus_a.mem_c_en) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_after: got %0d active cycles after release, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_stall();
        test_load_half();
        test_misaligned();
        test_mem_error();
        test_random();
        test_round_robin();
        test_fixed_priority();
        test_stall_limit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvm_mem_ctrl.md
Name: rvm_mem_ctrl

Overview:
- Sequences the core's single memory port and shares it between two requesters: instruction fetch (feeds the fetch/decode unit) and data load/store (driven by the core control FSM).
- Arbitrates between the two, holds requests through mem_stall, and steers byte lanes for writes.
- Extracts and sign/zero-extends read data, and detects misalignment and stall time-outs.
- Sits between the core control logic and the top-level mem_* pins.

Parameters:
- ROUND_ROBIN, 1, 1 = two-way round-robin arbitration; 0 = data port always wins.
- STALL_LIMIT, 255, maximum consecutive stalled cycles before the transaction is aborted with error; 0 disables the limit.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active low.
- i_req  in  1  fetch request; i_addr held stable while high.
- i_addr  in  32  fetch byte address.
- i_rsp_valid  out  1  one-cycle fetch completion pulse.
- i_rdata  out  32  fetched word; valid with i_rsp_valid.
- i_error  out  1  fetch failed (mem_error, misaligned or timeout); valid with i_rsp_valid.
- d_req  in  1  data request; d_* fields held stable while high.
- d_wen  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- d_signed  in  1  sign-extend load result.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_rsp_valid  out  1  one-cycle data completion pulse.
- d_rdata  out  32  extended load result; 0 for stores.
- d_error  out  1  data access failed.
- d_misaligned  out  1  failure cause is misalignment or reserved size.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_rdata  in  32  memory read word.
- mem_wdata  out  32  lane-replicated write data.
- mem_c_en  out  1  access strobe.
- mem_b_en  out  4  write byte lanes; 0000 = read.
- mem_error  in  1  access error, sampled at completion.
- mem_stall  in  1  memory not ready; hold the access.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer favours data; stall counter 0.
- Asynchronous reset mid-transaction abandons the access. mem_c_en drops immediately and no response is issued.
- FSM states: IDLE, MEM, RSP.
- IDLE: sample i_req/d_req at the clock edge.
  - Both high: the pointer picks the winner, and the pointer then flips to the loser.
  - ROUND_ROBIN=0: data always wins.
  - Grant latches the address, size and write fields.
  - Aligned: next state MEM.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size 11, fetch with addr[1:0]!=0): next state RSP with error=1 and misaligned=1. Memory is not touched.
- MEM: drive mem_c_en=1 with mem_addr, mem_b_en and mem_wdata from registers.
  - Completion is a rising edge with mem_stall=0. At that edge, register rdata and mem_error, then go to RSP.
  - Stall: hold all mem_* stable and increment the stall counter. If it reaches STALL_LIMIT (nonzero), go to RSP with error=1.
- RSP: assert exactly one of i_rsp_valid / d_rsp_valid for one cycle together with rdata/error, then return to IDLE.
  - The requester must drop req in the RSP cycle; req still high in IDLE is a new request.
- Latency: request sampled at edge 0, mem_c_en in cycle 1, response pulse in cycle 2 with zero stalls. Add 1 cycle per stall cycle. Misaligned requests respond in cycle 1.
- Write lanes:
  - byte: b_en = 0001<<addr[1:0]; wdata = {4{d_wdata[7:0]}}.
  - half: b_en = 0011<<{addr[1],1'b0}; wdata = {2{d_wdata[15:0]}}.
  - word: b_en = 1111; wdata = d_wdata.
- Reads use b_en=0000 and mem_wdata=0.
- Load extraction: select the byte/half lane by addr[1:0], then sign- or zero-extend according to d_signed. Word loads are passed unchanged.
- An error response drives rdata=0.
- Response outputs are 0 outside their valid cycle.

Decomposition:
- Shared constants file holds the size encodings (SIZE_B/H/W), FSM state encodings and the b_en read code.
- Natural sub-module: rvm_lane_steer. It is purely combinational, takes size/addr/wdata/rdata/signed, and produces b_en, replicated wdata and extended rdata.
- The FSM, arbiter and stall counter stay in rvm_mem_ctrl.

Test Plan:
- Fetch i_addr=0x100, mem_rdata=0x00500093, no stall: mem_c_en in cycle 1 with mem_addr=0x100 and b_en=0; i_rsp_valid in cycle 2 with i_rdata=0x00500093 and i_error=0.
- Store byte d_addr=0x203, d_wdata=0xAB, 3 stall cycles: mem_b_en=1000 and mem_wdata=0xABABABAB, held stable for 4 cycles; d_rsp_valid in cycle 5.
- Load half signed d_addr=0x402, mem_rdata=0x8001_1234: d_rdata=0xFFFF8001. Same load unsigned: 0x00008001.
- Word load d_addr=0x301: no mem_c_en; d_rsp_valid in cycle 1 with d_error=1 and d_misaligned=1.
- i_req and d_req held high together for 4 transactions with ROUND_ROBIN=1: grants alternate D, I, D, I. With ROUND_ROBIN=0, all 4 go to D.
- STALL_LIMIT=4 with mem_stall stuck high: response error after 4 stall cycles. Separately, resetn low during MEM: all outputs 0 immediately and no response pulse after release.
